// File: rtl/bus_read_ctrl.sv
// Reader end of a shared tristate data bus. Each accepted request drives an
// address with an output-enable to the remote driver, waits a fixed settle
// time, samples the bus, releases it for one turnaround cycle, and buffers
// the captured word in a show-ahead FIFO with a valid/ready consumer side.
module bus_read_ctrl #(
    parameter int WIDTH       = 8,
    parameter int AW          = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [AW-1:0]    ADDR_IN,
    output logic             BUSY,
    output logic             DROPPED,
    output logic [AW-1:0]    BUS_ADDR,
    output logic             BUS_OE,
    input  logic [WIDTH-1:0] BUS_DATA,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic             FULL
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             dropped_q, dropped_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             full;
    logic             empty;
    logic             accept;
    logic             push;
    logic             pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Read sequencer: accept in IDLE, hold OE through the settle count, sample, turn around.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        addr_d    = addr_q;
        accept    = 1'b0;
        push      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START && !full) begin
                    accept  = 1'b1;
                    addr_d  = ADDR_IN;
                    wait_d  = 4'(WAIT_CYCLES);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (wait_q == 4'd0) begin
                    push    = 1'b1;
                    state_d = TURN;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Any request that is not taken this edge is reported, never queued.
        dropped_d = START && !accept;
    end

    // Capture FIFO bookkeeping; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        pop      = DOUT_READY && !empty;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and FIFO state registers; reset flushes everything and aborts any read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            wait_q    <= 4'd0;
            addr_q    <= '0;
            dropped_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            addr_q    <= addr_d;
            dropped_q <= dropped_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage; contents need no reset because the count gates visibility.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem_q[wr_ptr_q] <= BUS_DATA;
        end
    end

    assign BUSY       = (state_q != IDLE);
    assign BUS_OE     = (state_q == DRIVE);
    assign BUS_ADDR   = addr_q;
    assign DROPPED    = dropped_q;
    assign DOUT_VALID = !empty;
    assign FULL       = full;
    // Head word is forced to zero while empty so DOUT is defined out of reset.
    assign DOUT       = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_bus_read_ctrl.sv
// Bench for bus_read_ctrl: a default build (WAIT_CYCLES=2, DEPTH=4) exercised by
// a vector table, directed sequences and random traffic against a timeline
// model, plus a WAIT_CYCLES=0 build checked on back-to-back requests.
module tb_bus_read_ctrl;

    localparam int MW = 2;
    localparam int MD = 4;

    logic       clk;
    logic       rst, start, dout_ready;
    logic [7:0] addr_in, bus_data;
    logic       busy, dropped, bus_oe, dout_valid, full;
    logic [7:0] bus_addr, dout;

    logic       b_rst, b_start, b_ready;
    logic [7:0] b_addr, b_bus;
    logic       b_busy, b_dropped, b_oe, b_valid, b_full;
    logic [7:0] b_bus_addr, b_dout;

    int n_tests = 0;
    int n_fail  = 0;

    bus_read_ctrl #(.WIDTH(8), .AW(8), .WAIT_CYCLES(MW), .DEPTH(MD)) dut (
        .CLK(clk), .RST(rst), .START(start), .ADDR_IN(addr_in),
        .BUSY(busy), .DROPPED(dropped), .BUS_ADDR(bus_addr), .BUS_OE(bus_oe),
        .BUS_DATA(bus_data), .DOUT(dout), .DOUT_VALID(dout_valid),
        .DOUT_READY(dout_ready), .FULL(full)
    );

    bus_read_ctrl #(.WIDTH(8), .AW(8), .WAIT_CYCLES(0), .DEPTH(4)) dut_w0 (
        .CLK(clk), .RST(b_rst), .START(b_start), .ADDR_IN(b_addr),
        .BUSY(b_busy), .DROPPED(b_dropped), .BUS_ADDR(b_bus_addr), .BUS_OE(b_oe),
        .BUS_DATA(b_bus), .DOUT(b_dout), .DOUT_VALID(b_valid),
        .DOUT_READY(b_ready), .FULL(b_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- timeline reference model ----------------
    // A read accepted at edge a drives OE in cycles a+1..a+MW+1, samples the
    // bus at edge a+MW+1 and blocks new requests until edge a+MW+3.
    int         m_acc = -1;
    int         m_n = 0;
    int         m_last = 0;
    bit         m_on = 0;
    logic [7:0] m_q[$];
    logic [7:0] m_addr = 8'h00;
    logic       m_drop = 1'b0;

    always @(posedge clk) begin
        bit m_busy, m_full, m_pop, m_push, m_ok;
        if (rst) begin
            m_acc  = -1;
            m_q.delete();
            m_addr = 8'h00;
            m_drop = 1'b0;
            m_on   = 1;
        end else begin
            m_busy = (m_acc >= 0) && (m_n >= m_acc + 1) && (m_n <= m_acc + MW + 2);
            m_full = (m_q.size() == MD);
            m_pop  = (m_q.size() > 0) && dout_ready;
            m_push = (m_acc >= 0) && (m_n == m_acc + MW + 1);
            m_ok   = start && !m_busy && !m_full;
            if (m_pop) void'(m_q.pop_front());
            if (m_push) m_q.push_back(bus_data);
            m_drop = start && !m_ok;
            if (m_ok) begin
                m_acc  = m_n;
                m_addr = addr_in;
            end
        end
        m_last = m_n;
        m_n++;
    end

    always @(negedge clk) begin
        bit eb, eo;
        if (m_on) begin
            eb = (m_acc >= 0) && (m_last >= m_acc) && (m_last <= m_acc + MW + 1);
            eo = (m_acc >= 0) && (m_last >= m_acc) && (m_last <= m_acc + MW);
            chk("mdl_busy",  8'(busy),       8'(eb));
            chk("mdl_oe",    8'(bus_oe),     8'(eo));
            chk("mdl_addr",  bus_addr,       m_addr);
            chk("mdl_drop",  8'(dropped),    8'(m_drop));
            chk("mdl_valid", 8'(dout_valid), 8'(m_q.size() > 0));
            chk("mdl_full",  8'(full),       8'(m_q.size() == MD));
            chk("mdl_dout",  dout,           (m_q.size() > 0) ? m_q[0] : 8'h00);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic r, input logic st, input logic [7:0] ad,
                        input logic [7:0] bd, input logic rd);
        @(negedge clk);
        rst = r; start = st; addr_in = ad; bus_data = bd; dout_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [7:0] ad, input logic [7:0] bd, input logic rd_at_sample);
        step(1'b0, 1'b1, ad, bd, 1'b0);
        for (int i = 1; i <= MW + 2; i++)
            step(1'b0, 1'b0, 8'h00, bd, (i == MW + 1) ? rd_at_sample : 1'b0);
    endtask

    typedef struct packed {
        logic       start;
        logic [7:0] addr;
        logic [7:0] bus;
        logic       ready;
        logic       busy;
        logic       oe;
        logic [7:0] baddr;
        logic       valid;
        logic [7:0] dout;
        logic       drop;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_fill [4];
        exp_fill[0] = 8'h11; exp_fill[1] = 8'h22; exp_fill[2] = 8'h33; exp_fill[3] = 8'h44;

        //           st    addr   bus    rdy   busy  oe    baddr  vld   dout   drop
        tbl[0]  = '{1'b1, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 8'hA5, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 8'hA5, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h00, 1'b0};
        tbl[6]  = '{1'b1, 8'h77, 8'h00, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0};
        tbl[7]  = '{1'b1, 8'h12, 8'h00, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 8'hB6, 1'b0, 1'b1, 1'b0, 8'h77, 1'b1, 8'hB6, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 8'hB6, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 8'h00, 1'b0};

        rst = 1'b1; start = 1'b0; addr_in = 8'h00; bus_data = 8'h00; dout_ready = 1'b0;
        b_rst = 1'b1; b_start = 1'b0; b_addr = 8'h00; b_bus = 8'h00; b_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  8'(busy),       8'h00);
        chk("rst_oe",    8'(bus_oe),     8'h00);
        chk("rst_addr",  bus_addr,       8'h00);
        chk("rst_drop",  8'(dropped),    8'h00);
        chk("rst_valid", 8'(dout_valid), 8'h00);
        chk("rst_full",  8'(full),       8'h00);
        chk("rst_dout",  dout,           8'h00);
        @(negedge clk);
        b_rst = 1'b0;
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // single read and busy rejection, cycle by cycle
        for (int i = 0; i < 12; i++) begin
            step(1'b0, tbl[i].start, tbl[i].addr, tbl[i].bus, tbl[i].ready);
            chk($sformatf("tbl%0d_busy", i),  8'(busy),       8'(tbl[i].busy));
            chk($sformatf("tbl%0d_oe", i),    8'(bus_oe),     8'(tbl[i].oe));
            chk($sformatf("tbl%0d_addr", i),  bus_addr,       tbl[i].baddr);
            chk($sformatf("tbl%0d_valid", i), 8'(dout_valid), 8'(tbl[i].valid));
            chk($sformatf("tbl%0d_dout", i),  dout,           tbl[i].dout);
            chk($sformatf("tbl%0d_drop", i),  8'(dropped),    8'(tbl[i].drop));
        end

        // fill to full, reject a fifth request, drain in order
        for (int i = 0; i < 4; i++) do_read(8'(i), exp_fill[i], 1'b0);
        chk("fill_full",  8'(full),       8'h01);
        chk("fill_valid", 8'(dout_valid), 8'h01);
        step(1'b0, 1'b1, 8'h99, 8'h00, 1'b0);
        chk("fill_drop",  8'(dropped),    8'h01);
        chk("fill_oe",    8'(bus_oe),     8'h00);
        chk("fill_busy",  8'(busy),       8'h00);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_dout", i), dout, exp_fill[i]);
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        end
        chk("drain_valid", 8'(dout_valid), 8'h00);
        chk("drain_full",  8'(full),       8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // push and pop on the same edge
        do_read(8'h01, 8'h3A, 1'b0);
        chk("pp_first", dout, 8'h3A);
        do_read(8'h02, 8'h5A, 1'b1);
        chk("pp_valid", 8'(dout_valid), 8'h01);
        chk("pp_dout",  dout,           8'h5A);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        chk("pp_empty", 8'(dout_valid), 8'h00);

        // reset during the second OE cycle
        do_read(8'h10, 8'h66, 1'b0);
        step(1'b0, 1'b1, 8'h20, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("mrst_oe_pre", 8'(bus_oe), 8'h01);
        step(1'b1, 1'b1, 8'h00, 8'h00, 1'b1);
        chk("mrst_oe",    8'(bus_oe),     8'h00);
        chk("mrst_busy",  8'(busy),       8'h00);
        chk("mrst_valid", 8'(dout_valid), 8'h00);
        chk("mrst_full",  8'(full),       8'h00);
        chk("mrst_addr",  bus_addr,       8'h00);
        chk("mrst_drop",  8'(dropped),    8'h00);
        do_read(8'h21, 8'hC3, 1'b0);
        chk("mrst_new_valid", 8'(dout_valid), 8'h01);
        chk("mrst_new_dout",  dout,           8'hC3);
        chk("mrst_new_addr",  bus_addr,       8'h21);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        // random traffic checked by the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 2) != 0),
                 8'($urandom),
                 8'($urandom),
                 (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        // WAIT_CYCLES=0 build: continuous START, one read every 3 cycles, 8 reads
        for (int j = 0; j < 26; j++) begin
            @(negedge clk);
            b_start = (j <= 21);
            b_addr  = 8'(j);
            b_bus   = 8'(8'h80 + j);
            @(posedge clk);
            #1;
            chk($sformatf("w0_%0d_oe", j),    8'(b_oe),      8'((j % 3 == 0) && (j <= 21)));
            chk($sformatf("w0_%0d_busy", j),  8'(b_busy),    8'((j % 3 != 2) && (j <= 22)));
            chk($sformatf("w0_%0d_drop", j),  8'(b_dropped), 8'((j % 3 != 0) && (j <= 21)));
            chk($sformatf("w0_%0d_valid", j), 8'(b_valid),   8'((j % 3 == 1) && (j <= 22)));
            chk($sformatf("w0_%0d_dout", j),  b_dout,
                ((j % 3 == 1) && (j <= 22)) ? 8'(8'h80 + j) : 8'h00);
            if (j % 3 == 0 && j <= 21)
                chk($sformatf("w0_%0d_addr", j), b_bus_addr, 8'(j));
        end
        chk("w0_full", 8'(b_full), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
